// File: rtl/gmii_pkg.sv
// Shared GMII definitions: parser FSM states, sub-header type codes,
// preamble/SFD bytes and CRC-32 constants (also used by gmii_tx).
package gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_HDR, ST_SUB, ST_PAY, ST_FCS, ST_DROP
  } rx_state_t;

  localparam logic [7:0]  TYPE_VIDEO    = 8'h01;
  localparam logic [7:0]  TYPE_AUDIO    = 8'h02;
  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Residue of a good frame, expressed in normal (MSB-first) bit order.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  // The CRC register shifts LSB-first; reverse it to compare with CRC_RESIDUE.
  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    for (int i = 0; i < 32; i++) bitrev32[i] = x[31-i];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One byte step of the reflected Ethernet CRC-32 (LSB of the byte first).
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  d_i,
  output logic [31:0] crc_o
);

  // Eight serial LFSR steps unrolled into one combinational stage.
  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d_i[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx_parser.sv
// GMII receive parser: strips preamble/MAC header, checks EtherType and
// sub-header, and rebuilds 48-bit video / 12-bit audio FIFO words.
// Optional FCS check is compiled in with `define RX_CRC_CHECK_EN.
module gmii_rx_parser
  import gmii_pkg::*;
#(
  parameter logic [15:0] ETHTYPE   = 16'h88B5,
  parameter logic [10:0] MAX_WORDS = 11'd1280
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        id,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [47:0] vdin,
  output logic        vwr_en,
  input  logic        vfull,
  output logic [11:0] adin,
  output logic        awr_en,
  input  logic        afull,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] ovf_cnt
);

  rx_state_t   state_q;
  logic [3:0]  cnt_q;       // header / sub-header / FCS byte index, byte-in-word in PAY
  logic [10:0] wcnt_q;      // words completed in this frame
  logic [10:0] nwords_q;    // word count from sub-header
  logic [7:0]  hi_q;        // high byte of EtherType, then of N
  logic        is_video_q;
  logic [39:0] sh_q;        // payload bytes of the word in progress
  logic [47:0] vdin_q;
  logic [11:0] adin_q;
  logic        vpend_q, apend_q;
  logic        ok_q, err_q;
  logic [15:0] ovf_q;
  logic        crc_good;

  wire [10:0] n_in   = {hi_q[2:0], rxd};
  wire        last_b = is_video_q ? (cnt_q == 4'd5) : (cnt_q == 4'd1);

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  crc32_d8 u_crc (.crc_i(crc_q), .d_i(rxd), .crc_o(crc_d));

  // CRC runs from the first dst MAC byte through the 4th FCS byte.
  always_ff @(posedge rx_clk or posedge sys_rst) begin
    if (sys_rst) crc_q <= CRC_INIT;
    else if (rx_dv) begin
      if (state_q == ST_PRE && rxd == SFD) crc_q <= CRC_INIT;
      else if (state_q inside {ST_HDR, ST_SUB, ST_PAY} ||
               (state_q == ST_FCS && cnt_q != 4'd4)) crc_q <= crc_d;
    end
  end

  assign crc_good = (bitrev32(crc_q) == CRC_RESIDUE);
`else
  assign crc_good = 1'b1;
`endif

  // Frame FSM with registered word data, write pending flags and status pulses.
  always_ff @(posedge rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      nwords_q   <= '0;
      hi_q       <= '0;
      is_video_q <= 1'b0;
      sh_q       <= '0;
      vdin_q     <= '0;
      adin_q     <= '0;
      vpend_q    <= 1'b0;
      apend_q    <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= '0;
    end else begin
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      vpend_q <= 1'b0;
      apend_q <= 1'b0;
      // A pending word that met a full FIFO is lost; parsing goes on.
      if (((vpend_q && vfull) || (apend_q && afull)) && ovf_q != 16'hFFFF)
        ovf_q <= ovf_q + 16'd1;

      case (state_q)
        ST_IDLE: if (rx_dv && rxd == PREAMBLE) state_q <= ST_PRE;
        default: begin
          if (!rx_dv) begin
            // End of carrier: only a fully counted FCS is a good frame.
            state_q <= ST_IDLE;
            if (state_q == ST_FCS && cnt_q == 4'd4 && crc_good) ok_q  <= 1'b1;
            else                                                err_q <= 1'b1;
          end else if (rx_er) begin
            state_q <= ST_DROP;
          end else begin
            case (state_q)
              ST_PRE: begin
                if (rxd == SFD) begin
                  state_q <= ST_HDR;
                  cnt_q   <= '0;
                end else if (rxd != PREAMBLE) state_q <= ST_DROP;
              end
              ST_HDR: begin
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'd12) hi_q <= rxd;
                if (cnt_q == 4'd13) begin
                  cnt_q   <= '0;
                  state_q <= ({hi_q, rxd} == ETHTYPE) ? ST_SUB : ST_DROP;
                end
              end
              ST_SUB: begin
                cnt_q <= cnt_q + 4'd1;
                case (cnt_q)
                  4'd0: if (rxd != {7'b0, id}) state_q <= ST_DROP;
                  4'd1: begin
                    if (rxd == TYPE_VIDEO)      is_video_q <= 1'b1;
                    else if (rxd == TYPE_AUDIO) is_video_q <= 1'b0;
                    else                        state_q    <= ST_DROP;
                  end
                  4'd2: hi_q <= rxd;
                  default: begin
                    cnt_q    <= '0;
                    wcnt_q   <= '0;
                    nwords_q <= n_in;
                    if (n_in > MAX_WORDS) state_q <= ST_DROP;
                    else if (n_in == '0)  state_q <= ST_FCS;
                    else                  state_q <= ST_PAY;
                  end
                endcase
              end
              ST_PAY: begin
                sh_q <= {sh_q[31:0], rxd};
                if (last_b) begin
                  cnt_q  <= '0;
                  wcnt_q <= wcnt_q + 11'd1;
                  if (is_video_q) begin
                    vdin_q  <= {sh_q, rxd};
                    vpend_q <= 1'b1;
                  end else begin
                    adin_q  <= {sh_q[3:0], rxd};
                    apend_q <= 1'b1;
                  end
                  if (wcnt_q + 11'd1 == nwords_q) state_q <= ST_FCS;
                end else begin
                  cnt_q <= cnt_q + 4'd1;
                end
              end
              // Bytes beyond the 4th FCS byte are ignored.
              ST_FCS: if (cnt_q != 4'd4) cnt_q <= cnt_q + 4'd1;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign vdin      = vdin_q;
  assign vwr_en    = vpend_q & ~vfull;
  assign adin      = adin_q;
  assign awr_en    = apend_q & ~afull;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign ovf_cnt   = ovf_q;

endmodule

// File: doc/gmii_rx_parser.md
Name: gmii_rx_parser

Overview:
- Receive-side counterpart of gmii_tx: parses GMII frames from the PHY and rebuilds video/audio FIFO words.
- Drives the write ports of the receive-side video FIFO (48-bit {1'b0,vcnt,1'b0,hcnt,tmds}) and audio FIFO (12-bit sample) that feed the HDMI output path.
- Single rx_clk domain; FIFOs perform the crossing to the pixel clock.

Parameters:
- ETHTYPE, 16'h88B5, accepted EtherType; any other value drops the frame.
- MAX_WORDS, 11'd1280, largest accepted word count; larger N drops the frame.

Ports:
- rx_clk  in  1  GMII receive clock, 125 MHz
- sys_rst  in  1  asynchronous reset, active-high
- id  in  1  stream id; frames with mismatched id are dropped
- rxd  in  8  GMII receive data
- rx_dv  in  1  GMII data valid
- rx_er  in  1  GMII receive error
- vdin  out  48  video FIFO write data
- vwr_en  out  1  video FIFO write strobe
- vfull  in  1  video FIFO full
- adin  out  12  audio FIFO write data
- awr_en  out  1  audio FIFO write strobe
- afull  in  1  audio FIFO full
- frame_ok  out  1  1-cycle pulse: frame fully parsed
- frame_err  out  1  1-cycle pulse: frame dropped or truncated
- ovf_cnt  out  16  count of words lost to full FIFO, saturating

Behaviour:
- Frame layout, bytes MSB-first:
  - preamble 0x55 x1..7, SFD 0xD5
  - dst MAC 6B, src MAC 6B (both ignored), EtherType 2B
  - sub-header: byte0 = {7'b0,id}; byte1 = type (0x01 video, 0x02 audio); bytes2-3 = N, word count, low 11 bits used
  - N words, then 4B FCS.
- Word formats: video word = 6 bytes, assembled MSB-first into vdin. Audio word = 2 bytes {4'b0,sample}; adin = low 12 bits.
- Reset: all outputs 0, ovf_cnt 0, FSM in IDLE.
- FSM states and transitions:
  - IDLE: rx_dv & rxd==0x55 -> PRE.
  - PRE: 0x55 stays in PRE; 0xD5 -> HDR; any other byte -> DROP.
  - HDR: 14-byte counter. EtherType != ETHTYPE at byte 13 -> DROP, else -> SUB.
  - SUB: 4-byte counter. Id mismatch, type not 0x01/0x02, or N > MAX_WORDS -> DROP. N==0 -> FCS, else -> PAY.
  - PAY: byte-in-word counter (0..5 video, 0..1 audio) plus word counter. After word N completes -> FCS.
  - FCS: counts 4 bytes; rx_dv low after the 4th byte -> frame_ok pulse, -> IDLE. Extra bytes after the FCS are ignored until rx_dv falls; frame_ok still pulses.
  - DROP: wait for rx_dv low, pulse frame_err, -> IDLE.
- Write latency: vwr_en/awr_en assert for 1 cycle, the cycle after the last byte of a word is sampled; data is stable in that cycle.
- Full FIFO: if vfull (afull) is high in the strobe cycle, suppress the strobe and increment ovf_cnt (saturates at 16'hFFFF). Parsing continues.
- rx_er high while rx_dv high, in any state except IDLE -> DROP. Words already written stay written.
- rx_dv falls before the FCS completes (PRE..FCS) -> frame_err pulse, -> IDLE. A partial word is discarded, never written.
- rx_dv low in IDLE: no effect. Back-to-back frames with 1 idle cycle are accepted.
- frame_ok and frame_err are never asserted in the same cycle.
- sys_rst mid-frame: immediate return to IDLE, strobes deasserted, ovf_cnt cleared.

Optional Feature:
- RX_CRC_CHECK_EN defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over dst MAC through FCS.
  - At frame end the residue must equal 0xC704DD7B. On mismatch, frame_err pulses instead of frame_ok.
  - Written words are not retracted.
- Macro undefined: no CRC logic; FCS bytes are only counted.

Decomposition:
- Shared package gmii_pkg:
  - FSM state enum
  - TYPE_VIDEO / TYPE_AUDIO constants
  - SFD/preamble constants
  - CRC polynomial and residue constants (shared with gmii_tx)
- One sub-module, crc32_d8: byte-wide CRC step, instantiated only under RX_CRC_CHECK_EN.

Test Plan:
- Video frame, N=2, words 48'h0_014_0DC_123456 and 48'h0_014_0DD_ABCDEF -> two vwr_en pulses with exact vdin, then frame_ok once.
- Audio frame, N=3, samples 0x123, 0xABC, 0xFFF -> three awr_en pulses, adin matches, frame_ok.
- EtherType 0x0800 -> no writes, frame_err when rx_dv falls; id=0 with port id=1 -> same response.
- rx_er pulsed mid-second video word -> first word written, second not written, frame_err.
- vfull held high for a 4-word video frame -> no vwr_en, ovf_cnt==4, frame_ok.
- With RX_CRC_CHECK_EN defined: correct FCS -> frame_ok; one FCS bit flipped -> frame_err.
